uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
Serial receiver for the host UART link, the receiving end of the baud-tick/transmit path. It recovers bit timing from the incoming line with its own resettable baud counter and samples each bit at mid-period. Received 8N1 bytes are delivered as a one-cycle strobe to the command/parser logic, with framing errors flagged.

Parameters:
CLKS_PER_BIT, 104, system clocks per bit period (12 MHz / 115200); minimum 8.
CNT_W, 16, width of the internal baud counter; must hold CLKS_PER_BIT-1.

Ports:
clk  input  1  system clock, all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
enable  input  1  receiver enable; low forces IDLE and clears the counter.
rx  input  1  asynchronous serial line, idle high.
data  output  8  last correctly received byte, held until the next good byte.
data_valid  output  1  one-cycle strobe; data is valid in the same cycle.
frame_error  output  1  one-cycle strobe when the stop bit samples low.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is rst_n, asynchronous and active-low.
- Reset values: data=0, data_valid=0, frame_error=0, busy=0, state=IDLE, counter=0, bit index=0. Synchroniser flops and the last-value flop reset to 1.
- Input path: rx passes through a 2-flop synchroniser (rx_s), giving 2 cycles of latency. A last-value flop provides falling-edge detection.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rx_s==0 and last==1 (falling edge), clear the counter and go to START.
- START: when the counter reaches CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0: clear the counter, set bit index=0, go to DATA.
  - Sample 1 (glitch): go to IDLE with no strobes.
- DATA: when the counter reaches CLKS_PER_BIT-1, sample rx_s into the shift register LSB-first and clear the counter.
  - After the 8th bit, go to STOP.
  - The bit index wraps from 7 to 0 only through the STOP path.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: data<=shift register, data_valid=1 for exactly one cycle, go to IDLE.
  - Sample 0: frame_error=1 for one cycle, data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This stops a break condition from generating repeated frames.
- Back-to-back frames: a start edge arriving in the cycle immediately after the STOP→IDLE transition is accepted with no gap required.
- enable low (synchronous, any state): next state IDLE, counter=0, no strobes issued; data keeps its value. enable high in IDLE with rx_s already low does not start a frame; only a falling edge does.
- Reset asserted mid-frame: all reset values apply immediately; a partial byte is discarded.
- data_valid and frame_error are never high in the same cycle.
- Counter arithmetic: unsigned CNT_W bits, compared for equality only, never allowed to wrap.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit decision (start, data, stop) is a 2-of-3 majority of rx_s sampled at counter values M-1, M and M+1, where M is the nominal sample point. The decision is made at M+1, so each bit decision is one cycle later.
- Undefined: single sample at M, as described in Behaviour.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg: state enumeration constants (IDLE..WAIT_IDLE), DATA_BITS=8, default CLKS_PER_BIT=104.
- One natural sub-module, uart_rx_bit_timer: resettable counter with clear input and terminal/half-terminal pulse outputs, parameterised by CLKS_PER_BIT.
- The FSM, shifter and synchroniser stay in uart_rx_sampler.

Test Plan:
All tests use CLKS_PER_BIT=16 with majority voting disabled unless stated.
1. Send 0x55 as 8N1 → data=0x55. data_valid pulses once, 2+8+8*16+16+1 = 155 ±1 clocks after the rx falling edge; busy is high throughout the frame.
2. Drive rx low for 4 clocks, then high → no data_valid and no frame_error; busy returns low about 10 clocks after the edge; data unchanged.
3. Send 0xA3 with stop bit=0, holding rx low for 40 more clocks → frame_error pulses once; data keeps the prior value; busy stays high until rx returns high, then IDLE.
4. Send 0xA3 then 0x0F with zero idle gap → two data_valid strobes, 160 clocks apart, with data 0xA3 then 0x0F.
5. Deassert enable for 1 clock during bit 3 of 0xFF, then pulse rst_n low during the next frame's start bit → no strobes; after reset, data=0 and busy=0.
6. With UART_RX_MAJORITY_EN defined, send 0x5A with a 1-clock inverted glitch at each bit's nominal sample point → data=0x5A and data_valid pulses once, 1 clock later than in scenario 1's timing.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART receive path.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Baud counter for the receiver: counts up from a clear, saturates at the bit
// period and flags the half-bit and full-bit decision points.
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16,
    parameter int HALF_AT      = CLKS_PER_BIT / 2 - 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic half_o,
    output logic full_o
);

    localparam logic [CNT_W-1:0] FULL_V = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_V = CNT_W'(HALF_AT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holding at FULL_V keeps the counter from ever wrapping, even if a
    // decision point were missed.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != FULL_V)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers, regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_o = (cnt_q == HALF_V);
    assign full_o = (cnt_q == FULL_V);

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample point.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif

    rx_state_e            state_q, state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fe_q, fe_d;

    logic rx_meta_q, rx_s_q, rx_last_q;
    logic bit_sample;
    logic tmr_clear, tmr_run, tmr_half, tmr_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_last_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_last_q <= rx_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Start-point offset of one cycle shifts every later decision by one, so
    // the vote window {prev2, last, current} straddles the nominal sample.
    logic rx_prev2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev2_q <= 1'b1;
        end else begin
            rx_prev2_q <= rx_last_q;
        end
    end

    assign bit_sample = maj3(rx_s_q, rx_last_q, rx_prev2_q);
`else
    assign bit_sample = rx_s_q;
`endif

    assign tmr_run = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W),
        .HALF_AT     (CLKS_PER_BIT / 2 - 1 + VOTE_LAG)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(tmr_clear),
        .run_i  (tmr_run),
        .half_o (tmr_half),
        .full_o (tmr_full)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        tmr_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (!rx_s_q && rx_last_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tmr_half) begin
                    tmr_clear = 1'b1;
                    if (!bit_sample) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tmr_full) begin
                    tmr_clear = 1'b1;
                    shift_d   = {bit_sample, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tmr_full) begin
                    tmr_clear = 1'b1;
                    bit_idx_d = '0;
                    if (bit_sample) begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                tmr_clear = 1'b1;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tmr_clear = 1'b1;
                state_d   = IDLE;
            end
        endcase

        if (!enable) begin
            state_d   = IDLE;
            bit_idx_d = '0;
            data_d    = data_q;
            dv_d      = 1'b0;
            fe_d      = 1'b0;
            tmr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = dv_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed frames plus random 8N1
// traffic, checked every cycle against a frame-level expectation queue.
module tb_uart_rx_sampler;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 156;
`else
    localparam int LAT = 155;
`endif

    typedef struct {
        int         cyc;
        logic       good;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int         cyc;
    int         checks;
    int         failures;
    logic       chk_en;
    logic [7:0] exp_data;
    exp_t       exp_q[$];
    int         strobe_cycs[$];
    exp_t       cur;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Every strobe must match the oldest outstanding expected frame, on its
    // exact cycle; data must always equal the last good byte.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (data_valid || frame_error) begin
                strobe_cycs.push_back(cyc);
                check("dv_fe_exclusive", int'(data_valid & frame_error), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", int'({data_valid, frame_error}), 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("strobe_cycle", cyc, cur.cyc);
                    check("strobe_dv", int'(data_valid), int'(cur.good));
                    check("strobe_fe", int'(frame_error), int'(!cur.good));
                    if (cur.good) exp_data = cur.data;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                check("missed_strobe", int'(data_valid | frame_error), 1);
                cur = exp_q.pop_front();
            end
            check("data_hold", int'(data), int'(exp_data));
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic glitch,
                              input logic expect_evt, input int en_drop_at, input int rst_at,
                              output int edge_o, output int busy_low);
        int   slot;
        logic bv;
        edge_o   = cyc;
        busy_low = 0;
        if (expect_evt) exp_q.push_back('{cyc: cyc + LAT, good: stop_bit, data: b});
        for (int n = 0; n < 10 * CPB; n++) begin
            slot = n / CPB;
            if (slot == 0)      bv = 1'b0;
            else if (slot == 9) bv = stop_bit;
            else                bv = b[slot-1];
            rx     = (glitch && (n % CPB) == CPB / 2) ? ~bv : bv;
            enable = (n != en_drop_at);
            if (rst_at >= 0 && n == rst_at) begin
                rst_n    = 1'b0;
                exp_q.delete();
                exp_data = 8'h00;
            end
            if (rst_at >= 0 && n == rst_at + 1) begin
                check("mid_reset_data", int'(data), 0);
                check("mid_reset_busy", int'(busy), 0);
                check("mid_reset_dv", int'(data_valid), 0);
            end
            if (rst_at >= 0 && n == rst_at + 2) rst_n = 1'b1;
            if (n >= 3 && n < LAT - 1 && !busy) busy_low++;
            @(negedge clk);
        end
        enable = 1'b1;
    endtask

    int e, bl, n0, gap;
    logic [7:0] rb;
    logic bad;

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        exp_data = 8'h00;
        rx       = 1'b1;
        enable   = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", int'(data), 0);
        check("reset_dv", int'(data_valid), 0);
        check("reset_fe", int'(frame_error), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        // Single good frame: latency and busy coverage.
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, -1, -1, e, bl);
        check("t1_data", int'(data), 8'h55);
        check("t1_latency", strobe_cycs[strobe_cycs.size()-1] - e, LAT);
        check("t1_busy_low_cycles", bl, 0);
        repeat (20) @(negedge clk);

        // Short start glitch.
        n0 = strobe_cycs.size();
        e  = cyc;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        wait_until(e + 5);
        check("t2_busy_during", int'(busy), 1);
        wait_until(e + 14);
        check("t2_busy_after", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("t2_no_strobes", strobe_cycs.size() - n0, 0);

        // Framing error followed by a held break.
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, -1, -1, e, bl);
        repeat (39) @(negedge clk);
        check("t3_busy_in_break", int'(busy), 1);
        @(negedge clk);
        rx = 1'b1;
        wait_until(e + 206);
        check("t3_busy_after_break", int'(busy), 0);
        check("t3_data_kept", int'(data), 8'h55);
        repeat (10) @(negedge clk);

        // Back-to-back frames with no idle gap.
        n0 = strobe_cycs.size();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, -1, -1, e, bl);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1, -1, e, bl);
        check("t4_strobes", strobe_cycs.size() - n0, 2);
        if (strobe_cycs.size() - n0 == 2)
            check("t4_gap", strobe_cycs[n0+1] - strobe_cycs[n0], 160);
        check("t4_data", int'(data), 8'h0F);
        repeat (10) @(negedge clk);

        // Enable pulse mid-frame, then reset during the next start bit.
        n0 = strobe_cycs.size();
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 70, -1, e, bl);
        repeat (5) @(negedge clk);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, 11, e, bl);
        repeat (20) @(negedge clk);
        check("t5_no_strobes", strobe_cycs.size() - n0, 0);
        check("t5_data_after_reset", int'(data), 0);
        check("t5_busy_after_reset", int'(busy), 0);

`ifdef UART_RX_MAJORITY_EN
        // Glitch on every nominal sample point is outvoted.
        n0 = strobe_cycs.size();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, -1, -1, e, bl);
        check("t6_data", int'(data), 8'h5A);
        check("t6_strobes", strobe_cycs.size() - n0, 1);
        check("t6_latency", strobe_cycs[strobe_cycs.size()-1] - e, 156);
        repeat (10) @(negedge clk);
`endif

        // Random traffic with random gaps and occasional bad stop bits.
        for (int k = 0; k < 14; k++) begin
            rb  = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_frame(rb, !bad, 1'b0, 1'b1, -1, -1, e, bl);
            if (bad) begin
                gap = int'($urandom_range(0, 30));
                repeat (gap) @(negedge clk);
                rx  = 1'b1;
                gap = 4 + int'($urandom_range(0, 3));
                repeat (gap) @(negedge clk);
            end else begin
                gap = int'($urandom_range(0, 20));
                repeat (gap) @(negedge clk);
            end
        end
        repeat (20) @(negedge clk);
        check("model_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
